// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output stage:
//   conv_state_e - control FSM states
//   sat_shift    - arithmetic shift, optional ReLU and saturation of one accumulator
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  // acc is the sign-extended accumulator; result is in the low out_w bits.
  // relu=1 clamps negatives to 0 and saturates to the unsigned out_w range,
  // relu=0 saturates to the signed out_w range.
  function automatic logic [31:0] sat_shift(input logic signed [63:0] acc,
                                            input int unsigned       shift,
                                            input int unsigned       out_w,
                                            input logic              relu);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v = acc >>> shift;
    if (relu) begin
      hi = $signed((64'd1 << out_w) - 64'd1);
      lo = '0;
    end else begin
      hi = $signed((64'd1 << (out_w - 1)) - 64'd1);
      lo = -$signed(64'd1 << (out_w - 1));
    end
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end
    return v[31:0];
  endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Show-ahead FIFO for processed pixels.
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : write i_data (ignored when full unless popping the same cycle)
//   i_pop     : drop head entry (ignored when empty; no bypass of a same-cycle push)
//   o_data    : head entry, valid while ~o_empty
//   o_full    : all DEPTH entries occupied
//   o_empty   : no entries
module conv_out_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer MSB distinguishes full from empty.
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_data    = r_mem[r_rd[AW-1:0]];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr[AW-1:0]] <= i_data;
        r_wr                <= r_wr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rd <= r_rd + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/conv_out_stage.sv
// Collects per-channel pixel events from a systolic array, arbitrates them
// round-robin, shifts/ReLUs/saturates them and queues them for a ready/valid
// consumer; tracks per-convolution completion.
//   clk, rst                 : clock, synchronous active-high reset
//   start, cfg_relu          : arm a convolution, ReLU mode sampled on start
//   in_valid/in_new/in_last  : per-channel event qualifier, toggle, last flag
//   in_accum                 : per-channel signed accumulators, channel c at [c*ACC_W +: ACC_W]
//   out_data/out_ch/out_last : head pixel, qualified by out_valid, accepted by out_ready
//   conv_done                : every channel's last pixel has been delivered
//   overflow                 : sticky, an event arrived while its channel was still pending
module conv_out_stage
  import conv_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cfg_relu,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_new,
  input  logic [NUM_CH-1:0]       in_last,
  input  logic [NUM_CH*ACC_W-1:0] in_accum,
  output logic [OUT_W-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    conv_done,
  output logic                    overflow
);

  localparam int unsigned FW = OUT_W + CH_W + 1;

  conv_state_e              r_state;
  conv_state_e              w_state_next;
  logic [NUM_CH-1:0]        r_prev_new;
  logic [NUM_CH-1:0]        r_pending;
  logic [NUM_CH-1:0]        r_last_seen;
  logic [NUM_CH-1:0]        r_hold_last;
  logic [ACC_W-1:0]         r_hold_val [NUM_CH];
  logic [CH_W-1:0]          r_rr;
  logic                     r_relu;
  logic                     r_overflow;
  logic                     r_conv_done;

  logic                     w_active;
  logic [NUM_CH-1:0]        w_event;
  logic                     w_grant_vld;
  logic [CH_W-1:0]          w_grant_ch;
  logic [NUM_CH-1:0]        w_grant_oh;
  logic signed [ACC_W-1:0]  w_sel_val;
  logic                     w_sel_last;
  logic [OUT_W-1:0]         w_pix;
  logic [FW-1:0]            w_fifo_din;
  logic [FW-1:0]            w_fifo_dout;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;

  // Events are only accepted while a convolution is in flight.
  assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_event  = in_valid & (in_new ^ r_prev_new);

  // Round-robin search starting at r_rr; no grant while the FIFO is full.
  always_comb begin : arb
    int unsigned idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant_ch  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(r_rr) + i) % NUM_CH;
      if (!w_grant_vld && r_pending[CH_W'(idx)] && !w_fifo_full) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    w_grant_oh = '0;
    if (w_grant_vld) begin
      w_grant_oh[w_grant_ch] = 1'b1;
    end
  end

  assign w_sel_val  = r_hold_val[w_grant_ch];
  assign w_sel_last = r_hold_last[w_grant_ch];
  assign w_pix      = OUT_W'(sat_shift(64'(w_sel_val), SHIFT, OUT_W, r_relu));
  assign w_fifo_din = {w_sel_last, w_grant_ch, w_pix};

  conv_out_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_grant_vld),
    .i_data  (w_fifo_din),
    .i_pop   (out_ready),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign {out_last, out_ch, out_data} = w_fifo_dout;
  assign out_valid = ~w_fifo_empty;
  assign conv_done = r_conv_done;
  assign overflow  = r_overflow;

  // Per-channel hold registers; a channel being granted can accept a new
  // event in the same cycle, otherwise a pending channel drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_new  <= '0;
      r_pending   <= '0;
      r_hold_last <= '0;
      r_overflow  <= 1'b0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        r_hold_val[c] <= '0;
      end
    end else begin
      r_prev_new <= in_new;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (w_active && w_event[c]) begin
          if (!r_pending[c] || w_grant_oh[c]) begin
            r_hold_val[c]  <= in_accum[c*ACC_W +: ACC_W];
            r_hold_last[c] <= in_last[c];
            r_pending[c]   <= 1'b1;
          end else begin
            r_overflow <= 1'b1;
          end
        end else if (w_grant_oh[c]) begin
          r_pending[c] <= 1'b0;
        end
      end
    end
  end

  // Control state, round-robin pointer and completion tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr        <= '0;
      r_relu      <= 1'b0;
      r_last_seen <= '0;
      r_conv_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_conv_done <= (w_state_next == ST_DONE);
      if (start) begin
        r_relu <= cfg_relu;
      end
      if (w_grant_vld) begin
        r_rr <= (w_grant_ch == CH_W'(NUM_CH - 1)) ? '0 : w_grant_ch + CH_W'(1);
      end
      if (start) begin
        r_last_seen <= '0;
      end else begin
        r_last_seen <= r_last_seen | (w_grant_oh & {NUM_CH{w_sel_last}});
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_RUN;
      ST_RUN: begin
        if (start)             w_state_next = ST_RUN;
        else if (&r_last_seen) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (start)                                w_state_next = ST_RUN;
        else if ((r_pending == '0) && w_fifo_empty) w_state_next = ST_DONE;
      end
      ST_DONE:  if (start) w_state_next = ST_RUN;
      default:  w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: doc/conv_out_stage.md
CONV_OUT_STAGE -- requirements
Module: conv_out_stage

Interface
REQ-001 Parameter NUM_CH, default 4, number of systolic output channels (1..8).
REQ-002 Parameter ACC_W, default 16, signed accumulator width per channel.
REQ-003 Parameter OUT_W, default 8, output pixel width (OUT_W < ACC_W).
REQ-004 Parameter SHIFT, default 0, arithmetic right-shift applied before saturation (0..ACC_W-OUT_W).
REQ-005 Parameter FIFO_DEPTH, default 8, output FIFO entries, power of two >= 2.
REQ-006 One clock; reset is synchronous and active-high: ports clk and rst.
REQ-007 clk  input  1  clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 start  input  1  one-cycle pulse; clears done, arms a new convolution.
REQ-010 cfg_relu  input  1  1 = clamp negative results to 0; sampled on start.
REQ-011 in_valid  input  NUM_CH  per-channel valid-pixel qualifier.
REQ-012 in_new  input  NUM_CH  per-channel new-pixel toggle.
REQ-013 in_last  input  NUM_CH  per-channel last-pixel flag, qualified with the same event.
REQ-014 in_accum  input  NUM_CH x ACC_W  per-channel signed accumulator.
REQ-015 out_data  output  OUT_W  processed pixel.
REQ-016 out_ch  output  max(1,clog2(NUM_CH))  source channel of out_data.
REQ-017 out_last  output  1  pixel is that channel's last.
REQ-018 out_valid  output  1  out_data/out_ch/out_last valid.
REQ-019 out_ready  input  1  consumer accepts when out_valid & out_ready.
REQ-020 conv_done  output  1  level, all channels' last pixels delivered.
REQ-021 overflow  output  1  sticky, a pixel event was dropped.

Function
REQ-022 Channel event in cycle N: in_valid[c] & (in_new[c] != prev_new[c]); prev_new[c] updates every cycle regardless of in_valid.
REQ-023 Event loads channel hold register (value, last) and sets pending[c] at end of cycle N.
REQ-024 Event on a channel with pending[c] set and not being granted in the same cycle: event dropped, hold unchanged, overflow set.
REQ-025 Round-robin arbiter grants one pending channel per cycle when FIFO not full, starting search at last grant + 1; grant clears pending[c]; grant and new event on same channel same cycle: new event loads, pending stays set.
REQ-026 Processing of granted value: arithmetic shift right by SHIFT; if relu_q and negative then 0; saturate to signed OUT_W range (relu_q=0) or to 0..2^OUT_W-1 with negatives to 0 (relu_q=1).
REQ-027 Processed pixel written to FIFO the grant cycle; out_valid asserted in cycle N+2 for an uncontended event in cycle N with empty FIFO.
REQ-028 FIFO is show-ahead; simultaneous push and pop allowed when full (pop frees slot same cycle) and when empty (no bypass; push appears next cycle).
REQ-029 out_data/out_ch/out_last held stable while out_valid & ~out_ready.
REQ-030 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN when last_seen set for all channels; DRAIN->DONE when pending all zero and FIFO empty; DONE->RUN on start.
REQ-031 last_seen[c] set on grant of a pixel with last=1; cleared on start.
REQ-032 Events in IDLE and DONE ignored (no pending, no overflow); prev_new still tracks.
REQ-033 conv_done = 1 only in state DONE.
REQ-034 start in RUN/DRAIN restarts: last_seen cleared, FIFO and pending preserved, state RUN.

Reset
REQ-035 rst clears FIFO pointers, pending, last_seen, prev_new, rr pointer (channel 0 first), relu_q, overflow; state IDLE.
REQ-036 Reset values: out_valid 0, out_data 0, out_ch 0, out_last 0, conv_done 0, overflow 0.
REQ-037 rst mid-operation discards all buffered pixels; no output the cycle after.

Structure
REQ-038 Shared package conv_pkg holds the FSM state enum and the saturation/shift helper function.
REQ-039 One sub-module: conv_out_fifo (parametrised width/depth, show-ahead, full/empty).

Verification
REQ-040 NUM_CH=4: single toggle on ch2, in_accum=0x0050, SHIFT=0, relu=0 -> out_data 0x50, out_ch 2, out_valid in cycle N+2.
REQ-041 Saturation: accum 0x0200 -> 0x7F; accum 0xFE00 -> 0x80; relu=1 with 0xFE00 -> 0x00; relu=1 with 0x0200 -> 0xFF.
REQ-042 All 4 channels toggle same cycle, out_ready=1 -> outputs ch0,1,2,3 on consecutive cycles.
REQ-043 out_ready=0 for 20 cycles, ch0 toggles 10 times -> FIFO fills (8 entries), later event on still-pending ch0 sets overflow; earlier 8 pixels drained in order.
REQ-044 start, each channel delivers last pixel, out_ready held 0 -> state DRAIN, conv_done 0; release out_ready -> conv_done 1 one cycle after final pop.
REQ-045 rst asserted with 3 entries in FIFO -> out_valid 0 next cycle, conv_done 0, overflow 0.
